// File: rtl/mem_byte_seq_if.sv
// mem_byte_seq_if: request/response and byte-RAM bus of the byte-sequencing memory controller
interface mem_byte_seq_if #(
    parameter int MADDR_SZ = 32
);
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [1:0]          req_size;
    logic                req_sext;
    logic [MADDR_SZ-1:0] req_addr;
    logic [63:0]         req_wdata;
    logic                resp_valid;
    logic [63:0]         resp_rdata;
    logic                resp_err;
    logic                ram_re;
    logic                ram_we;
    logic [MADDR_SZ-1:0] ram_raddr;
    logic [MADDR_SZ-1:0] ram_waddr;
    logic [7:0]          ram_datain;
    logic [7:0]          ram_dataout;

    modport master (
        output req_valid, req_we, req_size, req_sext, req_addr, req_wdata, ram_dataout,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  ram_re, ram_we, ram_raddr, ram_waddr, ram_datain
    );

    modport slave (
        input  req_valid, req_we, req_size, req_sext, req_addr, req_wdata, ram_dataout,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output ram_re, ram_we, ram_raddr, ram_waddr, ram_datain
    );
endinterface

// File: rtl/mem_byte_seq.sv
// mem_byte_seq: serialises 1/2/4/8-byte loads/stores into strobed little-endian byte accesses.
// Optional misalignment rejection: define MEM_BYTE_SEQ_ALIGN_CHECK_EN.
module mem_byte_seq #(
    parameter int MADDR_SZ = 32
) (
    input logic           clk,
    input logic           rst,
    mem_byte_seq_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, SAMPLE, RESP} state_t;

    state_t              state, next;
    logic                we, sext, bad, ready, re, wr, accept, last, misaligned, msb;
    logic [1:0]          size;
    logic [2:0]          k, nm1;
    logic [MADDR_SZ-1:0] addr;
    logic [7:0]          datain;
    logic [55:0]         wd;
    logic [63:0]         rd, mask;

    assign accept = bus.req_valid && ready;
    assign nm1    = {size == 2'd3, size[1], size != 2'd0};
    assign last   = k == nm1;

`ifdef MEM_BYTE_SEQ_ALIGN_CHECK_EN
    assign misaligned = (bus.req_addr[2:0] & {bus.req_size == 2'd3, bus.req_size[1], bus.req_size != 2'd0}) != 3'd0;
`else
    assign misaligned = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next;
    end

    // Next state; the registered misalignment verdict diverts SETUP straight to RESP
    always_comb begin
        next = state;
        case (state)
            IDLE:    next = accept ? SETUP : IDLE;
            SETUP:   next = bad ? RESP : STROBE;
            STROBE:  next = SAMPLE;
            SAMPLE:  next = last ? RESP : STROBE;
            RESP:    next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Request latch, byte stepping, load capture and registered glitch-free strobes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready  <= 1'b0;
            re     <= 1'b0;
            wr     <= 1'b0;
            we     <= 1'b0;
            size   <= 2'd0;
            sext   <= 1'b0;
            bad    <= 1'b0;
            k      <= 3'd0;
            addr   <= '0;
            datain <= 8'h00;
            wd     <= 56'd0;
            rd     <= 64'd0;
        end else begin
            ready <= next == IDLE;
            re    <= next == STROBE && !we;
            wr    <= next == STROBE && we;
            if (accept) begin
                we     <= bus.req_we;
                size   <= bus.req_size;
                sext   <= bus.req_sext;
                bad    <= misaligned;
                k      <= 3'd0;
                addr   <= bus.req_addr;
                datain <= bus.req_wdata[7:0];
                wd     <= bus.req_wdata[63:8];
                rd     <= 64'd0;
            end
            if (state == STROBE && !last) begin
                addr   <= addr + MADDR_SZ'(1);
                datain <= wd[7:0];
                wd     <= {8'h00, wd[55:8]};
            end
            if (state == SAMPLE) begin
                if (!we) rd[{k, 3'b000} +: 8] <= bus.ram_dataout;
                if (!last) k <= k + 3'd1;
            end
        end
    end

    // Width mask and sign bit of the assembled load value
    always_comb begin
        mask = size == 2'd0 ? 64'h0000_0000_0000_00FF :
               size == 2'd1 ? 64'h0000_0000_0000_FFFF :
               size == 2'd2 ? 64'h0000_0000_FFFF_FFFF : '1;
        msb  = size == 2'd0 ? rd[7] : size == 2'd1 ? rd[15] : size == 2'd2 ? rd[31] : rd[63];
    end

    assign bus.req_ready  = ready;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_err   = state == RESP && bad;
    assign bus.resp_rdata = (state == RESP && !we) ? (rd | ((sext && msb) ? ~mask : 64'd0)) : 64'd0;
    assign bus.ram_re     = re;
    assign bus.ram_we     = wr;
    assign bus.ram_raddr  = addr;
    assign bus.ram_waddr  = addr;
    assign bus.ram_datain = datain;
endmodule
